// File: rtl/hem_mux_cfg_seq_pkg.sv
// Shared definitions for the hem mux configuration sequencer.
package hem_mux_cfg_seq_pkg;

  localparam int unsigned CFG_W         = 8;
  localparam int unsigned MUX_W         = 2;
  localparam int unsigned CFG_EN_BIT    = 7;
  localparam int unsigned CFG_SWEEP_BIT = 6;
  localparam int unsigned CFG_SEL_LSB   = 4;
  localparam int unsigned CFG_SEL_W     = 2;
  localparam int unsigned CFG_DWELL_LSB = 0;
  localparam int unsigned CFG_DWELL_W   = 4;

  localparam logic [MUX_W-1:0] MUX_OFF = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATIC = 2'd1,
    ST_SWEEP  = 2'd2
  } state_e;

  typedef logic [CFG_W-1:0] cfg_word_t;

  typedef struct packed {
    state_e             state;
    logic [MUX_W-1:0]   mux;
  } target_t;

  // Dwell field of a config word.
  function automatic logic [CFG_DWELL_W-1:0] cfg_dwell(cfg_word_t w);
    return w[CFG_DWELL_LSB +: CFG_DWELL_W];
  endfunction

  // Controller state and mux value a freshly applied config word selects.
  function automatic target_t cfg_target(cfg_word_t w);
    target_t          t;
    logic [MUX_W-1:0] sel;
    sel     = w[CFG_SEL_LSB +: CFG_SEL_W];
    t.state = ST_IDLE;
    t.mux   = MUX_OFF;
    if (w[CFG_EN_BIT]) begin
      if (w[CFG_SWEEP_BIT]) begin
        t.state = ST_SWEEP;
        t.mux   = '0;
      end else if (sel != MUX_OFF) begin
        t.state = ST_STATIC;
        t.mux   = sel;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/hem_mux_cfg_seq_if.sv
// Scan chain and mux control signals of one taxel.
interface hem_mux_cfg_seq_if;
  import hem_mux_cfg_seq_pkg::*;

  logic             scan_en;
  logic             scan_in;
  logic             scan_out;
  logic             cfg_commit;
  logic [MUX_W-1:0] mux_config;
  logic             blank;
  logic             phase_strobe;

  modport master (
    output scan_en, scan_in, cfg_commit,
    input  scan_out, mux_config, blank, phase_strobe
  );

  modport slave (
    input  scan_en, scan_in, cfg_commit,
    output scan_out, mux_config, blank, phase_strobe
  );
endinterface

// File: rtl/hem_cfg_scan.sv
// Serial configuration shift register with shadow copy.
module hem_cfg_scan
  import hem_mux_cfg_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      scan_en,
  input  logic      scan_in,
  input  logic      cfg_commit,
  output cfg_word_t shift_q,
  output cfg_word_t shadow_q,
  output logic      scan_out
);

  // Shift MSB first; commit captures the word as it was before this cycle's shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      shadow_q <= '0;
    end else begin
      if (scan_en) shift_q <= {shift_q[CFG_W-2:0], scan_in};
      if (cfg_commit) shadow_q <= shift_q;
    end
  end

  assign scan_out = shift_q[CFG_W-1];

endmodule

// File: rtl/hem_mux_cfg_seq.sv
// Hem source sequencer: static select or timed sweep, with strobe and blanking.
module hem_mux_cfg_seq
  import hem_mux_cfg_seq_pkg::*;
#(
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  hem_mux_cfg_seq_if.slave  bus
);

  localparam int unsigned BLANK_W = 3;

  cfg_word_t shift_w;
  cfg_word_t shadow_w;
  logic      scan_out_w;

  hem_cfg_scan u_scan (
    .clk        (clk),
    .rst        (rst),
    .scan_en    (bus.scan_en),
    .scan_in    (bus.scan_in),
    .cfg_commit (bus.cfg_commit),
    .shift_q    (shift_w),
    .shadow_q   (shadow_w),
    .scan_out   (scan_out_w)
  );

  state_e                 state_q, state_d;
  logic [MUX_W-1:0]       mux_q, mux_d;
  logic [CFG_DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  cfg_word_t              act_q, act_d;
  logic                   pend_q, pend_d;
  logic [BLANK_W-1:0]     blank_cnt_q, blank_cnt_d;
  logic                   blank_q;
  logic                   strobe_q;

  target_t   tgt_w;
  target_t   tgt_p;
  cfg_word_t pend_word;
  logic      pend_eff;
  logic      boundary;

  // Next-state: commits, sweep stepping, pending hand-over and blank countdown.
  // The shadow always holds the latest commit, so it is the pending word.
  always_comb begin
    state_d     = state_q;
    mux_d       = mux_q;
    dwell_cnt_d = dwell_cnt_q;
    act_d       = act_q;
    pend_d      = 1'b0;
    blank_cnt_d = '0;
    pend_eff    = bus.cfg_commit ? (shift_w != act_q) : pend_q;
    pend_word   = bus.cfg_commit ? shift_w : shadow_w;
    tgt_w       = cfg_target(shift_w);
    tgt_p       = cfg_target(pend_word);
    boundary    = (dwell_cnt_q == cfg_dwell(act_q));

    if (bus.cfg_commit && !shift_w[CFG_EN_BIT]) begin
      state_d     = ST_IDLE;
      mux_d       = MUX_OFF;
      dwell_cnt_d = '0;
      act_d       = shift_w;
    end else begin
      case (state_q)
        ST_SWEEP: begin
          pend_d = pend_eff;
          if (boundary) begin
            dwell_cnt_d = '0;
            if (pend_eff) begin
              state_d = tgt_p.state;
              mux_d   = tgt_p.mux;
              act_d   = pend_word;
              pend_d  = 1'b0;
            end else begin
              mux_d = (mux_q == 2'd2) ? 2'd0 : mux_q + 2'd1;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + 4'd1;
          end
        end
        default: begin
          if (bus.cfg_commit) begin
            state_d     = tgt_w.state;
            mux_d       = tgt_w.mux;
            dwell_cnt_d = '0;
            act_d       = shift_w;
          end
        end
      endcase
    end

    if (mux_d != mux_q) begin
      blank_cnt_d = BLANK_W'(BLANK_CYC);
    end else if (blank_cnt_q != '0) begin
      blank_cnt_d = blank_cnt_q - 3'd1;
    end
  end

  // State and output registers; reset drops everything without a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mux_q       <= MUX_OFF;
      dwell_cnt_q <= '0;
      act_q       <= '0;
      pend_q      <= 1'b0;
      blank_cnt_q <= '0;
      blank_q     <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mux_q       <= mux_d;
      dwell_cnt_q <= dwell_cnt_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      blank_cnt_q <= blank_cnt_d;
      blank_q     <= (blank_cnt_d != '0);
      strobe_q    <= (mux_d != mux_q);
    end
  end

  assign bus.mux_config   = mux_q;
  assign bus.blank        = blank_q;
  assign bus.phase_strobe = strobe_q;
  assign bus.scan_out     = scan_out_w;

endmodule

// File: tb/tb_hem_mux_cfg_seq.sv
// Directed and randomized checks of hem_mux_cfg_seq against a behavioural model.
module tb_hem_mux_cfg_seq;

  localparam int BLANK_CYC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hem_mux_cfg_seq_if bus ();

  hem_mux_cfg_seq #(.BLANK_CYC(BLANK_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = off, 1 = fixed source, 2 = sweeping.
  int m_shift, m_act, m_mode, m_mux, m_age, m_pend, m_pend_word, m_blank_left, m_strobe;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_apply(input int w);
    int sel;
    sel   = (w / 16) % 4;
    m_act = w;
    if (w < 128) begin
      m_mode = 0; m_mux = 3;
    end else if (((w / 64) % 2) == 1) begin
      m_mode = 2; m_mux = 0; m_age = 1;
    end else if (sel == 3) begin
      m_mode = 0; m_mux = 3;
    end else begin
      m_mode = 1; m_mux = sel;
    end
  endtask

  task automatic m_clock(input bit r, input bit se, input bit si, input bit cc);
    int w, old;
    if (r) begin
      m_shift = 0; m_act = 0; m_mode = 0; m_mux = 3; m_age = 1;
      m_pend = 0; m_pend_word = 0; m_blank_left = 0; m_strobe = 0;
      return;
    end
    w   = m_shift;
    old = m_mux;
    if (se) m_shift = (m_shift * 2 + int'(si)) % 256;
    if (cc && w < 128) begin
      m_apply(w);
      m_pend = 0;
    end else if (m_mode == 2) begin
      if (cc) begin
        m_pend      = (w != m_act) ? 1 : 0;
        m_pend_word = w;
      end
      if (m_age == (m_act % 16) + 1) begin
        if (m_pend != 0) begin
          m_pend = 0;
          m_apply(m_pend_word);
        end else begin
          m_mux = (m_mux + 1) % 3;
          m_age = 1;
        end
      end else begin
        m_age++;
      end
    end else if (cc) begin
      m_apply(w);
    end
    m_strobe = (m_mux != old) ? 1 : 0;
    if (m_strobe != 0) m_blank_left = BLANK_CYC;
    else if (m_blank_left > 0) m_blank_left--;
  endtask

  task automatic step(input bit r, input bit se, input bit si, input bit cc);
    rst            = r;
    bus.scan_en    = se;
    bus.scan_in    = si;
    bus.cfg_commit = cc;
    @(posedge clk);
    m_clock(r, se, si, cc);
    #1;
    chk("mux_config", 8'(bus.mux_config), 8'(m_mux));
    chk("phase_strobe", 8'(bus.phase_strobe), 8'(m_strobe));
    chk("blank", 8'(bus.blank), (m_blank_left > 0) ? 8'd1 : 8'd0);
    chk("scan_out", 8'(bus.scan_out), 8'((m_shift / 128) % 2));
  endtask

  task automatic shift_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) step(1'b0, 1'b1, w[i], 1'b0);
  endtask

  int exp_seq[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
  bit bits[20];

  initial begin
    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_mux", 8'(bus.mux_config), 8'd3);
    chk("rst_blank", 8'(bus.blank), 8'd0);
    chk("rst_scan_out", 8'(bus.scan_out), 8'd0);

    // Static select 2
    shift_word(8'hA0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("static_mux", 8'(bus.mux_config), 8'd2);
    chk("static_strobe", 8'(bus.phase_strobe), 8'd1);
    chk("static_blank0", 8'(bus.blank), 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("static_strobe_off", 8'(bus.phase_strobe), 8'd0);
    chk("static_blank1", 8'(bus.blank), 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("static_blank2", 8'(bus.blank), 8'd0);

    // Identical recommit: no strobe, no blank
    shift_word(8'hA0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("recommit_strobe", 8'(bus.phase_strobe), 8'd0);
    chk("recommit_blank", 8'(bus.blank), 8'd0);

    // Sweep with dwell 2
    shift_word(8'hC2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i != 0) step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("sweep_seq", 8'(bus.mux_config), 8'(exp_seq[i]));
      chk("sweep_strobe", 8'(bus.phase_strobe),
          (i == 0 || exp_seq[i] != exp_seq[i-1]) ? 8'd1 : 8'd0);
    end

    // Disable mid-sweep
    shift_word(8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("disable_mux", 8'(bus.mux_config), 8'd3);
    chk("disable_blank0", 8'(bus.blank), 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("disable_blank1", 8'(bus.blank), 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("disable_blank2", 8'(bus.blank), 8'd0);

    // Pending commit mid-phase with dwell 3
    shift_word(8'hC3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    shift_word(8'h90);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pend_hold0", 8'(bus.mux_config), 8'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pend_hold1", 8'(bus.mux_config), 8'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pend_hold2", 8'(bus.mux_config), 8'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pend_apply_mux", 8'(bus.mux_config), 8'd1);
    chk("pend_apply_strobe", 8'(bus.phase_strobe), 8'd1);

    // Scan and commit in the same cycle, then scan_out latency
    shift_word(8'hA0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("scan_commit_mux", 8'(bus.mux_config), 8'd2);
    for (int j = 0; j < 20; j++) begin
      bits[j] = 1'($urandom_range(1, 0));
      step(1'b0, 1'b1, bits[j], 1'b0);
      if (j >= 7) chk("scan_delay", 8'(bus.scan_out), 8'(bits[j-7]));
    end

    // Reset mid-sweep
    shift_word(8'hC2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_sweep_mux", 8'(bus.mux_config), 8'd3);
    chk("rst_sweep_blank", 8'(bus.blank), 8'd0);
    chk("rst_sweep_strobe", 8'(bus.phase_strobe), 8'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_strobe", 8'(bus.phase_strobe), 8'd0);
      chk("post_rst_blank", 8'(bus.blank), 8'd0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 300) == 0, ($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 10) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hem_mux_cfg_seq.md
HEM_MUX_CFG_SEQ -- requirements
Module: hem_mux_cfg_seq

Interface
REQ-001 SHALL have parameter BLANK_CYC, default 2: cycles the blank output is held high after every mux_config change (range 1..7).
REQ-002 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 scan_en  input  1  shift enable for the serial configuration chain.
REQ-006 scan_in  input  1  serial configuration data, MSB first.
REQ-007 scan_out  output  1  shift_reg[7], registered, for daisy-chaining to the next taxel.
REQ-008 cfg_commit  input  1  single-cycle pulse: copy shift_reg into the shadow configuration.
REQ-009 mux_config  output  2  hem source select for the downstream one-hot encoder; 2'd3 = all sources off.
REQ-010 blank  output  1  high while the hem input settles after a source change.
REQ-011 phase_strobe  output  1  one-cycle pulse in the cycle mux_config takes a new value.

Function
REQ-012 Config word fields SHALL be: [7] en, [6] sweep, [5:4] sel, [3:0] dwell.
REQ-013 While scan_en=1, SHALL shift each cycle: shift_reg <= {shift_reg[6:0], scan_in}.
REQ-014 On cfg_commit=1, SHALL load shadow <= shift_reg using the pre-shift value, even if scan_en=1 in the same cycle.
REQ-015 Controller states SHALL be IDLE, STATIC and SWEEP:
- IDLE: mux_config=3.
- STATIC: mux_config=sel; sel=3 maps to IDLE.
- SWEEP: mux_config steps 0->1->2->0...
REQ-016 A commit with en=0 SHALL force IDLE in the next cycle from any state, sweep included.
REQ-017 A commit with en=1 while in IDLE or STATIC SHALL take effect in the next cycle: STATIC if sweep=0, SWEEP starting at phase 0 if sweep=1.
REQ-018 In SWEEP, each phase SHALL last dwell+1 cycles; dwell=0 gives a change every cycle.
REQ-019 A commit with en=1 while in SWEEP SHALL be held pending and applied at the next phase boundary, replacing that boundary's step; a later commit overwrites a pending one (latest wins).
REQ-020 mux_config SHALL never take the value 3 in SWEEP.
REQ-021 phase_strobe SHALL pulse for exactly one cycle coincident with every change of mux_config, and only then.
REQ-022 blank SHALL be high for BLANK_CYC cycles starting at each change; a new change during blanking SHALL restart the count.
REQ-023 Recommitting an identical config SHALL produce no strobe and no blank.

Reset
REQ-024 While rst=1, SHALL set: shift_reg=0, shadow=0, pending cleared, state=IDLE.
REQ-025 Outputs during reset: mux_config=3, blank=0, phase_strobe=0, scan_out=0.
REQ-026 Reset mid-sweep SHALL abandon the phase immediately, with no strobe on the reset cycle.
REQ-027 Leaving reset SHALL not itself generate a strobe or blank.

Structure
REQ-028 A shared package SHALL hold the config field positions, the state encoding (IDLE/STATIC/SWEEP), MUX_OFF=2'd3 and CFG_W=8.
REQ-029 The serial shift/shadow logic SHALL be one sub-module, hem_cfg_scan; the controller, dwell counter and blank counter stay in the top.
REQ-030 mux_config SHALL be driven directly from a register, not decoded combinationally.

Verification
REQ-031 Static select, reset duration: shift 8'hA0, commit -> mux_config 3->2 next cycle; strobe one cycle; blank high exactly 2 cycles.
REQ-032 Sweep sequence: shift 8'hC2, commit -> mux_config sequence 0,0,0,1,1,1,2,2,2,0; strobe on each change.
REQ-033 Pending commit mid-sweep: during sweep with dwell=3, commit 8'h90 mid-phase -> current phase completes its 4 cycles, then mux_config=1 (STATIC).
REQ-034 Disable mid-sweep: commit 8'h00 mid-phase -> mux_config=3 next cycle; blank 2 cycles.
REQ-035 Scan and commit in the same cycle: scan_en and cfg_commit both high -> shadow gets the pre-shift word; scan_out reproduces scan_in delayed by 8 cycles.
REQ-036 Reset mid-sweep: assert rst -> mux_config=3, blank=0, no strobe; after release, no strobe or blank until the next commit.
